imu_sample_sequencer: RTL

- Drives the command word of the accel/magnetometer I2C sensor driver.
- Issues the one-shot init pulse, then periodic handshake read requests.
- After a fixed settle time, latches the driver's six axis registers and block-averages 2^LOG2_AVG consecutive sample sets.
- Presents signed 16-bit averaged axes with a one-cycle valid strobe to the tracking logic downstream.

---
 rtl/imu_sample_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/imu_sample_sequencer.sv
// Sequences the IMU I2C driver: one init pulse, periodic read handshakes,
// then block-averages 2^LOG2_AVG sample sets of the six axis registers.
module imu_sample_sequencer #(
  parameter int SAMPLE_PERIOD = 10000000,
  parameter int SETTLE_CYCLES = 2000000,
  parameter int LOG2_AVG      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [31:0] cmd,
  input  logic [31:0] raw_acl_x,
  input  logic [31:0] raw_acl_y,
  input  logic [31:0] raw_acl_z,
  input  logic [31:0] raw_mag_x,
  input  logic [31:0] raw_mag_y,
  input  logic [31:0] raw_mag_z,
  output logic [15:0] avg_acl_x,
  output logic [15:0] avg_acl_y,
  output logic [15:0] avg_acl_z,
  output logic [15:0] avg_mag_x,
  output logic [15:0] avg_mag_y,
  output logic [15:0] avg_mag_z,
  output logic        avg_valid,
  output logic        busy
);

  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int AW = 16 + LOG2_AVG;
  localparam int CW = LOG2_AVG + 1;
  localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] COUNT_LAST  = CW'((1 << LOG2_AVG) - 1);

  typedef enum logic [2:0] {
    INIT,
    INIT_SETTLE,
    WAIT_PERIOD,
    ISSUE,
    READ_SETTLE,
    LATCH
  } state_t;

  state_t          state_reg, state_next;
  logic [SW-1:0]   settle_cnt_reg;
  logic [PW-1:0]   period_cnt_reg;
  logic [15:0]     idx_reg;
  logic [15:0]     cmd_idx_reg, cmd_idx_next;
  logic            cmd_init_reg, cmd_init_next;
  logic [CW-1:0]   count_reg;
  logic            avg_valid_reg;
  logic            settle_done, period_expired, issue_go, latch_now, window_done;
  logic [31:0]     raw [6];
  logic [15:0]     avg_all [6];
  logic [5:0]      unused_upper;

  assign raw[0] = raw_acl_x;
  assign raw[1] = raw_acl_y;
  assign raw[2] = raw_acl_z;
  assign raw[3] = raw_mag_x;
  assign raw[4] = raw_mag_y;
  assign raw[5] = raw_mag_z;

  assign settle_done    = (settle_cnt_reg == SETTLE_LAST);
  assign period_expired = (period_cnt_reg == PERIOD_LAST);
  assign latch_now      = (state_reg == LATCH);
  assign window_done    = latch_now && (count_reg == COUNT_LAST);

  // cmd is registered: the index is loaded on the WAIT_PERIOD exit so it shows during ISSUE
  always_comb begin
    state_next    = state_reg;
    issue_go      = 1'b0;
    cmd_init_next = 1'b0;
    cmd_idx_next  = cmd_idx_reg;
    busy          = 1'b1;
    case (state_reg)
      INIT: begin
        cmd_init_next = 1'b1;
        state_next    = INIT_SETTLE;
      end
      INIT_SETTLE: if (settle_done) state_next = WAIT_PERIOD;
      WAIT_PERIOD: begin
        busy = 1'b0;
        if (enable && period_expired) begin
          issue_go     = 1'b1;
          cmd_idx_next = idx_reg;
          state_next   = ISSUE;
        end
      end
      ISSUE:       state_next = READ_SETTLE;
      READ_SETTLE: if (settle_done) state_next = LATCH;
      LATCH:       state_next = WAIT_PERIOD;
      default:     state_next = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= INIT;
      settle_cnt_reg <= '0;
      period_cnt_reg <= '0;
      idx_reg        <= 16'd1;
      cmd_idx_reg    <= '0;
      cmd_init_reg   <= 1'b0;
      count_reg      <= '0;
      avg_valid_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cmd_init_reg  <= cmd_init_next;
      cmd_idx_reg   <= cmd_idx_next;
      avg_valid_reg <= window_done;
      if (state_reg == INIT_SETTLE || state_reg == READ_SETTLE)
        settle_cnt_reg <= settle_done ? '0 : settle_cnt_reg + SW'(1);
      else
        settle_cnt_reg <= '0;
      // Leaving init with the timer expired lets the first read go out at once
      if (issue_go)
        period_cnt_reg <= '0;
      else if (state_reg == INIT_SETTLE && settle_done)
        period_cnt_reg <= PERIOD_LAST;
      else if (!period_expired)
        period_cnt_reg <= period_cnt_reg + PW'(1);
      if (latch_now) begin
        idx_reg   <= idx_reg + 16'd1;
        count_reg <= window_done ? '0 : count_reg + CW'(1);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_axis
      logic signed [AW-1:0] acc_reg;
      logic signed [AW-1:0] sample_ext;
      logic signed [AW-1:0] sum;
      logic [15:0]          avg_reg;

      assign sample_ext = AW'($signed(raw[gi][15:0]));
      assign sum        = acc_reg + sample_ext;

      always_ff @(posedge clk) begin
        if (rst) begin
          acc_reg <= '0;
          avg_reg <= '0;
        end else if (latch_now) begin
          if (window_done) begin
            acc_reg <= '0;
            avg_reg <= 16'(sum >>> LOG2_AVG);
          end else begin
            acc_reg <= sum;
          end
        end
      end

      assign avg_all[gi]      = avg_reg;
      assign unused_upper[gi] = ^raw[gi][31:16];
    end
  endgenerate

  assign cmd       = {15'b0, cmd_idx_reg, cmd_init_reg};
  assign avg_valid = avg_valid_reg;
  assign avg_acl_x = avg_all[0];
  assign avg_acl_y = avg_all[1];
  assign avg_acl_z = avg_all[2];
  assign avg_mag_x = avg_all[3];
  assign avg_mag_y = avg_all[4];
  assign avg_mag_z = avg_all[5];

endmodule
